// File: rtl/stream_packet_arbiter.sv
// Round-robin, packet-atomic arbiter merging NUM_PORTS valid/ready streams into one
// registered output stream tagged with the index of the source that produced each beat.
module stream_packet_arbiter #(
  parameter int WIDTH     = 32,
  parameter int NUM_PORTS = 4,
  parameter int ID_WIDTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS*WIDTH-1:0] stream_s_data_i,
  input  logic [NUM_PORTS-1:0]       stream_s_last_i,
  input  logic [NUM_PORTS-1:0]       stream_s_valid_i,
  output logic [NUM_PORTS-1:0]       stream_s_ready_o,
  output logic [WIDTH-1:0]           stream_m_data_o,
  output logic                       stream_m_last_o,
  output logic [ID_WIDTH-1:0]        stream_m_id_o,
  output logic                       stream_m_valid_o,
  input  logic                       stream_m_ready_i,
  output logic                       busy_o
);

  // Handshake: a beat moves on a rising edge where valid and ready are both high;
  // ready never depends on the same side's valid, and valid/data hold until accepted.

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] rr_q, rr_d;
  logic [ID_WIDTH-1:0] pick;
  logic [ID_WIDTH-1:0] next_rr;
  logic                any_valid;
  logic                src_valid, src_last, src_ready, src_fire;
  logic [WIDTH-1:0]    src_data;

  // First requesting port at or after the round-robin pointer, with wrap-around.
  always_comb begin
    int j;
    j         = 0;
    pick      = '0;
    any_valid = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = int'(rr_q) + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!any_valid && stream_s_valid_i[j]) begin
        any_valid = 1'b1;
        pick      = ID_WIDTH'(j);
      end
    end
  end

  always_comb begin
    src_valid = stream_s_valid_i[grant_q];
    src_last  = stream_s_last_i[grant_q];
    src_data  = stream_s_data_i[int'(grant_q)*WIDTH +: WIDTH];
    // Accept when the output register is empty or being drained this cycle.
    src_ready = (state_q == LOCKED) && (stream_m_ready_i || !stream_m_valid_o);
    src_fire  = src_ready && src_valid;
    next_rr   = (grant_q == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
    stream_s_ready_o          = '0;
    stream_s_ready_o[grant_q] = src_ready;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d = pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (src_fire && src_last) begin
          state_d = IDLE;
          rr_d    = next_rr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stream_m_valid_o <= 1'b0;
      stream_m_data_o  <= '0;
      stream_m_last_o  <= 1'b0;
      stream_m_id_o    <= '0;
    end else if (src_fire) begin
      stream_m_valid_o <= 1'b1;
      stream_m_data_o  <= src_data;
      stream_m_last_o  <= src_last;
      stream_m_id_o    <= grant_q;
    end else if (stream_m_valid_o && stream_m_ready_i) begin
      stream_m_valid_o <= 1'b0;
    end
  end

  assign busy_o = (state_q == LOCKED);

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Directed table-driven bench for stream_packet_arbiter (4 ports, 32-bit data);
// port k always presents row data + k*0x100 so the source is visible in the output.
module tb_stream_packet_arbiter;

  localparam int WIDTH     = 32;
  localparam int NUM_PORTS = 4;
  localparam int ID_WIDTH  = 2;

  logic                       clk;
  logic                       rst;
  logic [NUM_PORTS*WIDTH-1:0] s_data;
  logic [NUM_PORTS-1:0]       s_last;
  logic [NUM_PORTS-1:0]       s_valid;
  logic [NUM_PORTS-1:0]       s_ready;
  logic [WIDTH-1:0]           m_data;
  logic                       m_last;
  logic [ID_WIDTH-1:0]        m_id;
  logic                       m_valid;
  logic                       m_ready;
  logic                       busy;

  int errors = 0;
  int checks = 0;

  stream_packet_arbiter #(
    .WIDTH(WIDTH), .NUM_PORTS(NUM_PORTS), .ID_WIDTH(ID_WIDTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stream_s_data_i  (s_data),
    .stream_s_last_i  (s_last),
    .stream_s_valid_i (s_valid),
    .stream_s_ready_o (s_ready),
    .stream_m_data_o  (m_data),
    .stream_m_last_o  (m_last),
    .stream_m_id_o    (m_id),
    .stream_m_valid_o (m_valid),
    .stream_m_ready_i (m_ready),
    .busy_o           (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs for one cycle, ready expected before the edge, outputs expected after it.
  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        mr;
    logic [3:0]  e_sr;
    logic        e_mv;
    logic [31:0] e_md;
    logic        e_ml;
    logic [1:0]  e_id;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] l, logic [31:0] d,
                              logic mr, logic [3:0] e_sr, logic e_mv, logic [31:0] e_md,
                              logic e_ml, logic [1:0] e_id, logic e_busy);
    vec_t x;
    x.rst = r; x.v = v; x.l = l; x.d = d; x.mr = mr;
    x.e_sr = e_sr; x.e_mv = e_mv; x.e_md = e_md; x.e_ml = e_ml; x.e_id = e_id;
    x.e_busy = e_busy;
    return x;
  endfunction

  // Driver tasks
  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                       input logic [31:0] d, input logic mr);
    rst     = r;
    s_valid = v;
    s_last  = l;
    m_ready = mr;
    for (int k = 0; k < NUM_PORTS; k++) s_data[k*WIDTH +: WIDTH] = d + 32'(k * 256);
  endtask

  // Scoreboard comparison
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    drive(1'b1, 4'b0000, 4'b0000, 32'h0, 1'b1);

    // reset
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 32'h00, 1, 4'b0000, 0, 32'h000, 0, 0, 0));
    // single-source packet on port 2
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 32'hA1, 1, 4'b0000, 0, 32'h000, 0, 0, 1));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 32'hA1, 1, 4'b0100, 1, 32'h2A1, 0, 2, 1));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 32'hA2, 1, 4'b0100, 1, 32'h2A2, 0, 2, 1));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 32'hA3, 1, 4'b0100, 1, 32'h2A3, 1, 2, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h00, 1, 4'b0000, 0, 32'h2A3, 1, 2, 0));
    // round-robin from reset, single-beat packets on all ports
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 32'hB0, 1, 4'b0000, 0, 32'h000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 32'hB0, 1, 4'b0000, 0, 32'h000, 0, 0, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 32'hB0, 1, 4'b0001, 1, 32'h0B0, 1, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 32'hB0, 1, 4'b0000, 0, 32'h0B0, 1, 0, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 32'hB0, 1, 4'b0010, 1, 32'h1B0, 1, 1, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 32'hB0, 1, 4'b0000, 0, 32'h1B0, 1, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 32'hB0, 1, 4'b0100, 1, 32'h2B0, 1, 2, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 32'hB0, 1, 4'b0000, 0, 32'h2B0, 1, 2, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 32'hB0, 1, 4'b1000, 1, 32'h3B0, 1, 3, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 32'hB0, 1, 4'b0000, 0, 32'h3B0, 1, 3, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 32'hB0, 1, 4'b0001, 1, 32'h0B0, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h00, 1, 4'b0000, 0, 32'h0B0, 1, 0, 0));
    // packet atomicity: port 0 four beats, port 1 requests from beat 2
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 32'hC0, 1, 4'b0000, 0, 32'h0B0, 1, 0, 1));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 32'hC0, 1, 4'b0001, 1, 32'h0C0, 0, 0, 1));
    vecs.push_back(mk(0, 4'b0011, 4'b0000, 32'hC1, 1, 4'b0001, 1, 32'h0C1, 0, 0, 1));
    vecs.push_back(mk(0, 4'b0011, 4'b0000, 32'hC2, 1, 4'b0001, 1, 32'h0C2, 0, 0, 1));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, 32'hC3, 1, 4'b0001, 1, 32'h0C3, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0010, 4'b0010, 32'hD0, 1, 4'b0000, 0, 32'h0C3, 1, 0, 1));
    vecs.push_back(mk(0, 4'b0010, 4'b0010, 32'hD0, 1, 4'b0010, 1, 32'h1D0, 1, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h00, 1, 4'b0000, 0, 32'h1D0, 1, 1, 0));
    // backpressure on a 3-beat packet from port 3
    vecs.push_back(mk(0, 4'b1000, 4'b0000, 32'hE0, 1, 4'b0000, 0, 32'h1D0, 1, 1, 1));
    vecs.push_back(mk(0, 4'b1000, 4'b0000, 32'hE0, 1, 4'b1000, 1, 32'h3E0, 0, 3, 1));
    vecs.push_back(mk(0, 4'b1000, 4'b0000, 32'hE1, 0, 4'b0000, 1, 32'h3E0, 0, 3, 1));
    vecs.push_back(mk(0, 4'b1000, 4'b0000, 32'hE1, 0, 4'b0000, 1, 32'h3E0, 0, 3, 1));
    vecs.push_back(mk(0, 4'b1000, 4'b0000, 32'hE1, 1, 4'b1000, 1, 32'h3E1, 0, 3, 1));
    vecs.push_back(mk(0, 4'b1000, 4'b1000, 32'hE2, 0, 4'b0000, 1, 32'h3E1, 0, 3, 1));
    vecs.push_back(mk(0, 4'b1000, 4'b1000, 32'hE2, 1, 4'b1000, 1, 32'h3E2, 1, 3, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h00, 0, 4'b0000, 1, 32'h3E2, 1, 3, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h00, 1, 4'b0000, 0, 32'h3E2, 1, 3, 0));
    // source stall: port 0 drops valid for 5 cycles while ports 1,2 request
    vecs.push_back(mk(0, 4'b0111, 4'b0000, 32'hF0, 1, 4'b0000, 0, 32'h3E2, 1, 3, 1));
    vecs.push_back(mk(0, 4'b0111, 4'b0000, 32'hF0, 1, 4'b0001, 1, 32'h0F0, 0, 0, 1));
    for (int s = 0; s < 5; s++)
      vecs.push_back(mk(0, 4'b0110, 4'b0000, 32'hF1, 1, 4'b0001, 0, 32'h0F0, 0, 0, 1));
    vecs.push_back(mk(0, 4'b0111, 4'b0001, 32'hF1, 1, 4'b0001, 1, 32'h0F1, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0110, 4'b0110, 32'h60, 1, 4'b0000, 0, 32'h0F1, 1, 0, 1));
    vecs.push_back(mk(0, 4'b0110, 4'b0110, 32'h60, 1, 4'b0010, 1, 32'h160, 1, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h00, 1, 4'b0000, 0, 32'h160, 1, 1, 0));
    // reset during beat 2 of a port-2 packet; pointer restarts at 0 so port 1 wins
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 32'h70, 1, 4'b0000, 0, 32'h160, 1, 1, 1));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 32'h70, 1, 4'b0100, 1, 32'h270, 0, 2, 1));
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 32'h71, 1, 4'b0000, 0, 32'h000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0110, 4'b0000, 32'h80, 1, 4'b0000, 0, 32'h000, 0, 0, 1));
    vecs.push_back(mk(0, 4'b0110, 4'b0010, 32'h80, 1, 4'b0010, 1, 32'h180, 1, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h00, 1, 4'b0000, 0, 32'h180, 1, 1, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].mr);
      #1;
      check($sformatf("row%0d s_ready", i), 32'(s_ready), 32'(vecs[i].e_sr));
      @(posedge clk);
      #1;
      check($sformatf("row%0d m_valid", i), 32'(m_valid), 32'(vecs[i].e_mv));
      check($sformatf("row%0d m_data", i),  m_data,        vecs[i].e_md);
      check($sformatf("row%0d m_last", i),  32'(m_last),  32'(vecs[i].e_ml));
      check($sformatf("row%0d m_id", i),    32'(m_id),    32'(vecs[i].e_id));
      check($sformatf("row%0d busy", i),    32'(busy),    32'(vecs[i].e_busy));
    end

    // Asynchronous reset between edges while an output beat is stalled
    @(negedge clk);
    drive(1'b0, 4'b0100, 4'b0000, 32'h90, 1'b0);
    @(posedge clk);
    #1;
    check("async grant busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    check("async s_ready", 32'(s_ready), 32'b0100);
    @(posedge clk);
    #1;
    check("async loaded valid", 32'(m_valid), 32'd1);
    check("async loaded data", m_data, 32'h290);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async rst m_valid", 32'(m_valid), 32'd0);
    check("async rst m_data", m_data, 32'h0);
    check("async rst s_ready", 32'(s_ready), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    #1;
    drive(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    check("post rst idle busy", 32'(busy), 32'd0);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_packet_arbiter.md
Name: stream_packet_arbiter

Overview:
- Round-robin arbiter that shares one downstream valid/ready stream port between NUM_PORTS upstream stream sources.
- Grants are packet-atomic: once a source is granted, only that source is forwarded until its beat with last=1 is accepted.
- Output is fully registered (one-deep output stage); the forwarded beat carries the index of its source.
- Sits between several stream producers (test writers, DMA readers) and a single consumer such as a FIFO or serializer.

Parameters:
WIDTH, 32, data width per stream beat
NUM_PORTS, 4, number of upstream sources (>=1)
ID_WIDTH, 2, width of source index output; must satisfy 2**ID_WIDTH >= NUM_PORTS

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
stream_s_data_i  input  NUM_PORTS*WIDTH  source data, port k at [k*WIDTH+:WIDTH]
stream_s_last_i  input  NUM_PORTS  per-source end-of-packet flag
stream_s_valid_i  input  NUM_PORTS  per-source valid
stream_s_ready_o  output  NUM_PORTS  per-source ready
stream_m_data_o  output  WIDTH  forwarded data (registered)
stream_m_last_o  output  1  forwarded last flag (registered)
stream_m_id_o  output  ID_WIDTH  index of the source that produced the current output beat
stream_m_valid_o  output  1  output valid (registered)
stream_m_ready_i  input  1  downstream ready
busy_o  output  1  high while a grant is held (state LOCKED)

Behaviour:
- Reset, asynchronous: state=IDLE, grant=0, rr_ptr=0, stream_m_valid_o=0, stream_m_data_o=0, stream_m_last_o=0, stream_m_id_o=0, busy_o=0, stream_s_ready_o=0.
- Handshake: a transfer happens on a rising edge where valid and ready are both high.
- IDLE state:
  - stream_s_ready_o = all zero.
  - If any stream_s_valid_i bit is set, pick the first set index searching rr_ptr, rr_ptr+1, ... with wrap-around modulo NUM_PORTS.
  - On that edge: grant <= index, state <= LOCKED.
  - No data moves in the arbitration cycle, giving a one-cycle bubble per packet.
- LOCKED state:
  - stream_s_ready_o[grant] = stream_m_ready_i | ~stream_m_valid_o. All other ready bits are 0.
  - Ready must not depend on the source's own valid.
  - On a source handshake: stream_m_data_o, stream_m_last_o and stream_m_valid_o=1 are loaded, with stream_m_id_o <= grant.
  - On a source handshake with last=1: state <= IDLE and rr_ptr <= (grant+1) mod NUM_PORTS on the same edge.
- Output stage:
  - If stream_m_valid_o & stream_m_ready_i and no new beat is loaded, stream_m_valid_o <= 0.
  - Data and last hold their value while valid & ~ready.
  - Simultaneous drain and load gives full throughput: one beat per cycle inside a packet.
- Latency:
  - s_valid sampled high in IDLE at edge t.
  - The first beat is accepted at edge t+1.
  - stream_m_valid_o is high from edge t+1.
- busy_o = (state == LOCKED).
- Boundary conditions:
  - Granted source drops valid mid-packet: the grant stays held and the output stalls. There is no timeout and other sources are not served.
  - Downstream stall: stream_m_valid_o stays high and the output is stable until accepted.
  - Single-beat packet (last=1 on first beat): one LOCKED cycle, then IDLE.
  - NUM_PORTS=1: degenerates to a registered pass-through with a one-cycle bubble between packets.
  - Reset asserted mid-packet: everything returns to its reset value immediately. Any partial packet is dropped, and the source sees ready=0.
  - Valid asserted by a non-granted source during LOCKED: ignored until the next IDLE arbitration.
  - Pointer fairness: after serving port k, port k has the lowest priority in the next arbitration.

Test Plan:
- Single-source packet:
  - Stimulus: port 2 sends beats 0xA1, 0xA2, 0xA3 (last on 0xA3); m_ready=1.
  - Required: m_valid first high one edge after the grant edge; id=2 on all three beats; 3 consecutive output beats; busy_o drops after 0xA3 is accepted.
- Round-robin:
  - Stimulus: all 4 ports hold single-beat packets valid continuously from reset.
  - Required: grant order 0,1,2,3,0; each output beat is separated by exactly one bubble cycle.
- Packet atomicity:
  - Stimulus: port 0 sends a 4-beat packet; port 1 raises valid at the second beat.
  - Required: all 4 port-0 beats are output contiguously before any port-1 beat; stream_s_ready_o[1]=0 throughout.
- Backpressure:
  - Stimulus: m_ready toggles 1,0,0,1 during a 3-beat packet.
  - Required: no beat lost or duplicated; m_data stable while m_ready=0; source ready is low whenever the output register is full and not draining.
- Source stall:
  - Stimulus: the granted port drops valid for 5 cycles mid-packet while other ports are valid.
  - Required: busy_o stays 1; no other id appears; the packet resumes afterwards.
- Reset mid-packet:
  - Stimulus: rst pulsed during beat 2 of 4.
  - Required: m_valid=0 and all ready bits 0 immediately; after release, arbitration restarts from rr_ptr=0.
